// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - core/DMA arbiter for one synchronous-read data-memory port
// Core has fixed priority; a saturating starvation count force-grants a waiting DMA request.
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c_req,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [31:0]           c_wdata,
  input  logic [3:0]            c_we,
  output logic                  c_gnt,
  output logic [31:0]           c_rdata,
  output logic                  c_rvalid,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  input  logic [3:0]            d_we,
  output logic                  d_gnt,
  output logic [31:0]           d_rdata,
  output logic                  d_rvalid,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic [3:0]            mem_we,
  input  logic [31:0]           mem_dout
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

  logic [CNT_WIDTH-1:0] starve_cnt_q, starve_cnt_d;
  logic                 c_rvalid_q, c_rvalid_d;
  logic                 d_rvalid_q, d_rvalid_d;
  logic                 force_d;

  always_comb begin
    force_d = d_req && (starve_cnt_q >= LIMIT);
    d_gnt   = d_req && (!c_req || force_d);
    c_gnt   = c_req && !d_gnt;
    mem_en  = c_gnt || d_gnt;

    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 4'b0000;
    if (d_gnt) begin
      mem_addr = d_addr;
      mem_din  = d_wdata;
      mem_we   = d_we;
    end else if (c_gnt) begin
      mem_addr = c_addr;
      mem_din  = c_wdata;
      mem_we   = c_we;
    end

    // Count only consecutive denied cycles; a grant or a dropped request restarts it.
    starve_cnt_d = '0;
    if (d_req && !d_gnt) begin
      starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + CNT_WIDTH'(1);
    end

    c_rvalid_d = c_gnt && (c_we == 4'b0000);
    d_rvalid_d = d_gnt && (d_we == 4'b0000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      c_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      c_rvalid_q   <= c_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign c_rdata  = mem_dout;
  assign d_rdata  = mem_dout;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - randomized and directed bench for dmem_port_arbiter
module tb_dmem_port_arbiter;
  localparam int AW    = 14;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          c_req = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [31:0]   c_wdata = '0;
  logic [3:0]    c_we = '0;
  logic          c_gnt, c_rvalid;
  logic [31:0]   c_rdata;
  logic          d_req = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic [3:0]    d_we = '0;
  logic          d_gnt, d_rvalid;
  logic [31:0]   d_rdata;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [3:0]    mem_we;
  logic [31:0]   mem_dout;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_addr(c_addr), .c_wdata(c_wdata), .c_we(c_we),
    .c_gnt(c_gnt), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout)
  );

  // Synchronous-read BRAM with byte write enables.
  logic [31:0] bram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      if (mem_we == 4'b0000) mem_dout <= bram[mem_addr];
    end
  end

  // Reference model: memory contents, run of denied DMA cycles, pending read returns.
  logic [31:0] shadow [int];
  int          denied;
  bit          exp_crv, exp_drv;
  logic [31:0] exp_crd, exp_drd;
  int          vectors, miscompares;
  bit          o_cg, o_dg, o_crv, o_drv;
  logic [31:0] o_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic cycle(input bit cr, input logic [AW-1:0] ca, input logic [31:0] cw, input logic [3:0] cwe,
                       input bit dr, input logic [AW-1:0] da, input logic [31:0] dw, input logic [3:0] dwe);
    bit            ec, ed;
    logic [AW-1:0] ea;
    logic [31:0]   edin, word;
    logic [3:0]    ewe;
    @(posedge clk); #1;
    c_req = cr; c_addr = ca; c_wdata = cw; c_we = cwe;
    d_req = dr; d_addr = da; d_wdata = dw; d_we = dwe;
    @(negedge clk);
    ed = dr && (!cr || denied >= LIMIT);
    ec = cr && !ed;
    ea = '0; edin = '0; ewe = '0;
    if (ed) begin ea = da; edin = dw; ewe = dwe; end
    else if (ec) begin ea = ca; edin = cw; ewe = cwe; end
    chk("c_gnt", c_gnt, ec);
    chk("d_gnt", d_gnt, ed);
    chk("mem_en", mem_en, ec || ed);
    chk("mem_addr", mem_addr, ea);
    chk("mem_din", mem_din, edin);
    chk("mem_we", mem_we, ewe);
    chk("c_rvalid", c_rvalid, exp_crv);
    chk("d_rvalid", d_rvalid, exp_drv);
    if (exp_crv) chk("c_rdata", c_rdata, exp_crd);
    if (exp_drv) chk("d_rdata", d_rdata, exp_drd);
    o_cg = c_gnt; o_dg = d_gnt; o_crv = c_rvalid; o_drv = d_rvalid; o_rd = mem_dout;
    exp_crv = ec && (cwe == 4'b0000);
    exp_drv = ed && (dwe == 4'b0000);
    if (ec || ed) begin
      word = shadow.exists(int'(ea)) ? shadow[int'(ea)] : 32'hxxxx_xxxx;
      if (ewe == 4'b0000) begin
        exp_crd = word;
        exp_drd = word;
      end else begin
        for (int b = 0; b < 4; b++)
          if (ewe[b]) word[8*b +: 8] = edin[8*b +: 8];
        shadow[int'(ea)] = word;
      end
    end
    denied = ed ? 0 : (dr ? denied + 1 : 0);
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 4'b0, 1'b0, '0, '0, 4'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    chk("pre_rst_c_rvalid", c_rvalid, exp_crv);
    chk("pre_rst_d_rvalid", d_rvalid, exp_drv);
    rst = 1'b1; c_req = 1'b1; c_addr = 14'h005; c_we = 4'b0; c_wdata = '0;
    d_req = 1'b0; d_we = 4'b0;
    #1;
    chk("rst_c_gnt", c_gnt, 1'b1);
    chk("rst_c_rvalid", c_rvalid, 1'b0);
    chk("rst_d_rvalid", d_rvalid, 1'b0);
    @(posedge clk); #1;
    chk("rst_hold_c_rvalid", c_rvalid, 1'b0);
    rst = 1'b0; c_req = 1'b0; d_req = 1'b0;
    exp_crv = 1'b0; exp_drv = 1'b0; denied = 0;
    @(negedge clk);
    chk("post_rst_c_rvalid", c_rvalid, 1'b0);
    chk("post_rst_d_rvalid", d_rvalid, 1'b0);
  endtask

  initial begin
    logic [AW-1:0] pre_addr [12];
    logic [31:0]   pre_data [12];
    bit            rc, rdq, c_hold, d_hold;
    logic [AW-1:0] rca, rda;
    logic [31:0]   rcw, rdw;
    logic [3:0]    rcwe, rdwe;

    vectors = 0; miscompares = 0; denied = 0;
    exp_crv = 1'b0; exp_drv = 1'b0; exp_crd = '0; exp_drd = '0;
    pre_addr = '{14'h000, 14'h001, 14'h002, 14'h003, 14'h004, 14'h005,
                 14'h006, 14'h007, 14'h010, 14'h020, 14'h030, 14'h3FFF};
    pre_data = '{32'h0000_1000, 32'h0101_1001, 32'h0202_1002, 32'h0303_1003,
                 32'h0404_1004, 32'h0505_1005, 32'h0606_1006, 32'h0707_1007,
                 32'hDEAD_BEEF, 32'h1122_3344, 32'h0BAD_0BAD, 32'hCAFE_F00D};

    do_reset();
    for (int i = 0; i < 12; i++)
      cycle(1'b1, pre_addr[i], pre_data[i], 4'hF, 1'b0, '0, '0, 4'b0);

    // Core read
    cycle(1'b1, 14'h010, '0, 4'b0, 1'b0, '0, '0, 4'b0);
    chk("core_read_gnt", o_cg, 1'b1);
    idle();
    chk("core_read_rvalid", o_crv, 1'b1);
    chk("core_read_data", o_rd, 32'hDEAD_BEEF);
    chk("core_read_d_rvalid", o_drv, 1'b0);

    // Core byte store, then read back
    cycle(1'b1, 14'h020, 32'h00AB_0000, 4'b0100, 1'b0, '0, '0, 4'b0);
    cycle(1'b1, 14'h020, '0, 4'b0, 1'b0, '0, '0, 4'b0);
    chk("store_no_rvalid", o_crv, 1'b0);
    idle();
    chk("store_readback", o_rd, 32'h11AB_3344);

    // Continuous contention: DMA every fifth cycle
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 14'h001, '0, 4'b0, 1'b1, 14'h002, '0, 4'b0);
      chk("starve_d_gnt", o_dg, (i == 4 || i == 9));
      chk("starve_c_gnt", o_cg, !(i == 4 || i == 9));
    end
    idle();

    // DMA alone at the top address
    cycle(1'b0, '0, '0, 4'b0, 1'b1, 14'h3FFF, '0, 4'b0);
    chk("dma_alone_gnt", o_dg, 1'b1);
    idle();
    chk("dma_alone_rvalid", o_drv, 1'b1);
    chk("dma_alone_data", o_rd, 32'hCAFE_F00D);

    // Dropped DMA request restarts the starvation count
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 14'h003, '0, 4'b0, 1'b1, 14'h004, '0, 4'b0);
      chk("drop_pre_d_gnt", o_dg, 1'b0);
    end
    cycle(1'b1, 14'h003, '0, 4'b0, 1'b0, '0, '0, 4'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 14'h003, '0, 4'b0, 1'b1, 14'h004, '0, 4'b0);
      chk("drop_post_d_gnt", o_dg, (i == 4));
    end
    idle();

    // DMA write followed by core read of the same word
    cycle(1'b0, '0, '0, 4'b0, 1'b1, 14'h030, 32'h5A5A_1234, 4'hF);
    cycle(1'b1, 14'h030, '0, 4'b0, 1'b0, '0, '0, 4'b0);
    idle();
    chk("cross_read_data", o_rd, 32'h5A5A_1234);

    // Reset while a read return is in flight
    cycle(1'b1, 14'h010, '0, 4'b0, 1'b0, '0, '0, 4'b0);
    do_reset();

    // Random traffic; requesters hold until granted, DMA may drop occasionally
    c_hold = 1'b0; d_hold = 1'b0;
    rc = 1'b0; rca = '0; rcw = '0; rcwe = '0;
    rdq = 1'b0; rda = '0; rdw = '0; rdwe = '0;
    for (int n = 0; n < 400; n++) begin
      if (!c_hold) begin
        rc   = ($urandom_range(0, 3) != 0);
        rca  = pre_addr[$urandom_range(0, 11)];
        rcw  = $urandom;
        rcwe = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom);
      end
      if (!d_hold || $urandom_range(0, 7) == 0) begin
        rdq  = ($urandom_range(0, 1) != 0);
        rda  = pre_addr[$urandom_range(0, 11)];
        rdw  = $urandom;
        rdwe = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom);
      end
      cycle(rc, rca, rcw, rcwe, rdq, rda, rdw, rdwe);
      c_hold = rc && !o_cg;
      d_hold = rdq && !o_dg;
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
